// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: control-flow encodings, fetch FSM states
// and the default reset vector.
package mips_pkg;

   localparam logic [1:0] BR_COND = 2'b00;
   localparam logic [1:0] BR_J    = 2'b01;
   localparam logic [1:0] BR_JR   = 2'b10;
   localparam logic [1:0] BR_RSVD = 2'b11;

   typedef logic [1:0] state_t;

   localparam state_t RESET = 2'd0;
   localparam state_t FETCH = 2'd1;
   localparam state_t HOLD  = 2'd2;
   localparam state_t DRAIN = 2'd3;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

endpackage

// File: rtl/branch_target.sv
// Combinational redirect target for beq/bne, j/jal and jr, plus the jr
// word-alignment check.
module branch_target
   import mips_pkg::*;
(
   input  logic [1:0]  br_type,
   input  logic [25:0] br_imm,
   input  logic [31:0] br_reg,
   input  logic [31:0] br_pc,
   output logic [31:0] target,
   output logic        misalign
);

   logic [31:0] seq_pc_s;
   logic [31:0] offset_s;

   assign seq_pc_s = br_pc + 32'd4;
   // 18-bit byte offset {imm16,2'b00}; bits 31..18 replicate imm[15]
   assign offset_s = {{14{br_imm[15]}}, br_imm[15:0], 2'b00};

   // Select the target for the presented control-flow kind
   always_comb begin
      target = seq_pc_s;
      case (br_type)
         BR_COND: target = seq_pc_s + offset_s;
         BR_J:    target = {seq_pc_s[31:28], br_imm, 2'b00};
         BR_JR:   target = {br_reg[31:2], 2'b00};
         default: target = seq_pc_s;
      endcase
   end

   assign misalign = (br_type == BR_JR) && (br_reg[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: owns the PC, fetches over req/ack, hands words
// to decode over valid/ready and applies redirects resolved in execute.
module pc_sequencer
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        br_valid,
   input  logic [1:0]  br_type,
   input  logic        br_taken,
   input  logic [25:0] br_imm,
   input  logic [31:0] br_reg,
   input  logic [31:0] br_pc,
   output logic [31:0] pc,
   output logic        misalign
);

   state_t      state_r;
   state_t      state_nxt_s;
   logic [31:0] pc_r;
   logic [31:0] pc_nxt_s;
   logic [31:0] instr_r;
   logic [31:0] instr_pc_r;
   logic        instr_valid_r;
   logic        imem_req_r;
   logic        misalign_r;
   logic        capture_s;
   logic        redirect_s;
   logic [31:0] target_s;
   logic        misalign_s;

   branch_target u_branch_target (
      .br_type  (br_type),
      .br_imm   (br_imm),
      .br_reg   (br_reg),
      .br_pc    (br_pc),
      .target   (target_s),
      .misalign (misalign_s)
   );

   assign redirect_s = br_valid &&
                       (((br_type == BR_COND) && br_taken) ||
                        (br_type == BR_J) || (br_type == BR_JR));

   // Next state and next PC; a redirect takes priority over ack/ready
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      capture_s   = 1'b0;
      case (state_r)
         RESET: begin
            state_nxt_s = FETCH;
         end
         FETCH: begin
            if (redirect_s) begin
               pc_nxt_s    = target_s;
               state_nxt_s = imem_ack ? FETCH : DRAIN;
            end else if (imem_ack) begin
               capture_s   = 1'b1;
               pc_nxt_s    = pc_r + 32'd4;
               state_nxt_s = HOLD;
            end else begin
               state_nxt_s = FETCH;
            end
         end
         HOLD: begin
            if (redirect_s) begin
               pc_nxt_s    = target_s;
               state_nxt_s = FETCH;
            end else if (instr_ready) begin
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = HOLD;
            end
         end
         DRAIN: begin
            // A late redirect retargets; the abandoned ack still ends the drain
            if (redirect_s) begin
               pc_nxt_s = target_s;
            end else begin
               pc_nxt_s = pc_r;
            end
            if (imem_ack) begin
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: begin
            state_nxt_s = RESET;
         end
      endcase
   end

   // State, PC and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= RESET;
         pc_r          <= RESET_PC;
         instr_r       <= 32'd0;
         instr_pc_r    <= 32'd0;
         instr_valid_r <= 1'b0;
         imem_req_r    <= 1'b0;
         misalign_r    <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         pc_r          <= pc_nxt_s;
         instr_valid_r <= (state_nxt_s == HOLD);
         imem_req_r    <= (state_nxt_s == FETCH);
         misalign_r    <= br_valid && misalign_s;
         if (capture_s) begin
            instr_r    <= imem_rdata;
            instr_pc_r <= pc_r;
         end else begin
            instr_r    <= instr_r;
            instr_pc_r <= instr_pc_r;
         end
      end
   end

   assign imem_req    = imem_req_r;
   assign imem_addr   = pc_r;
   assign instr       = instr_r;
   assign instr_pc    = instr_pc_r;
   assign instr_valid = instr_valid_r;
   assign pc          = pc_r;
   assign misalign    = misalign_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: redirect vectors from HOLD in a table,
// hand-written sequences for streaming, drain, squash and reset corners.
module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        br_valid;
   logic [1:0]  br_type;
   logic        br_taken;
   logic [25:0] br_imm;
   logic [31:0] br_reg;
   logic [31:0] br_pc;
   logic [31:0] pc;
   logic        misalign;

   int n_tests = 0;
   int n_fail  = 0;

   pc_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .br_valid    (br_valid),
      .br_type     (br_type),
      .br_taken    (br_taken),
      .br_imm      (br_imm),
      .br_reg      (br_reg),
      .br_pc       (br_pc),
      .pc          (pc),
      .misalign    (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  ty;
      logic        taken;
      logic [25:0] imm;
      logic [31:0] rv;
      logic [31:0] bpc;
      logic        exp_redir;
      logic [31:0] exp_tgt;
      logic        exp_mis;
   } vec_t;

   vec_t vecs [9];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic clear_br;
      br_valid = 1'b0;
      br_type  = 2'b00;
      br_taken = 1'b0;
      br_imm   = 26'd0;
      br_reg   = 32'd0;
      br_pc    = 32'd0;
   endtask

   // Reset and leave the DUT in FETCH at the reset vector
   task automatic reset_dut;
      rst = 1'b1;
      imem_ack = 1'b0;
      instr_ready = 1'b0;
      clear_br();
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{2'b00, 1'b1, 26'h000FFFC, 32'h0, 32'h0040_0010, 1'b1, 32'h0040_0004, 1'b0};
      vecs[1] = '{2'b00, 1'b1, 26'h0000003, 32'h0, 32'h0040_0010, 1'b1, 32'h0040_0020, 1'b0};
      vecs[2] = '{2'b01, 1'b0, 26'h0000100, 32'h0, 32'h1FFF_FFFC, 1'b1, 32'h2000_0400, 1'b0};
      vecs[3] = '{2'b10, 1'b0, 26'h0000000, 32'h0040_0103, 32'h0, 1'b1, 32'h0040_0100, 1'b1};
      vecs[4] = '{2'b00, 1'b0, 26'h000FFFC, 32'h0, 32'h0040_0010, 1'b0, 32'h0, 1'b0};
      vecs[5] = '{2'b11, 1'b1, 26'h0000010, 32'h0040_0200, 32'h0040_0010, 1'b0, 32'h0, 1'b0};
      vecs[6] = '{2'b10, 1'b1, 26'h0000000, 32'h1234_5678, 32'h0, 1'b1, 32'h1234_5678, 1'b0};
      vecs[7] = '{2'b00, 1'b1, 26'h0008000, 32'h0, 32'h0000_0000, 1'b1, 32'hFFFE_0004, 1'b0};
      vecs[8] = '{2'b00, 1'b1, 26'h0007FFF, 32'h0, 32'h0040_0000, 1'b1, 32'h0042_0000, 1'b0};

      rst = 1'b1;
      imem_ack = 1'b0;
      imem_rdata = 32'd0;
      instr_ready = 1'b0;
      clear_br();
      tick();
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_addr", imem_addr, 32'h0040_0000);
      check("rst_instr", instr, 32'd0);
      check("rst_instr_pc", instr_pc, 32'd0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_pc", pc, 32'h0040_0000);
      check("rst_misalign", {31'd0, misalign}, 32'd0);

      // Zero-wait memory, decode always ready
      rst = 1'b0;
      instr_ready = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         check("stream_req", {31'd0, imem_req}, 32'd1);
         check("stream_addr", imem_addr, 32'h0040_0000 + 32'(i) * 32'd4);
         check("stream_valid_lo", {31'd0, instr_valid}, 32'd0);
         imem_ack = 1'b1;
         imem_rdata = 32'hA000_0000 + 32'(i);
         tick();
         imem_ack = 1'b0;
         check("stream_valid_hi", {31'd0, instr_valid}, 32'd1);
         check("stream_instr", instr, 32'hA000_0000 + 32'(i));
         check("stream_instr_pc", instr_pc, 32'h0040_0000 + 32'(i) * 32'd4);
         check("stream_req_lo", {31'd0, imem_req}, 32'd0);
         tick();
      end

      // Redirect vectors presented in HOLD with decode stalled
      for (int v = 0; v < 9; v++) begin
         reset_dut();
         imem_ack = 1'b1;
         imem_rdata = 32'h0C0F_FEE0;
         tick();
         imem_ack = 1'b0;
         br_valid = 1'b1;
         br_type  = vecs[v].ty;
         br_taken = vecs[v].taken;
         br_imm   = vecs[v].imm;
         br_reg   = vecs[v].rv;
         br_pc    = vecs[v].bpc;
         tick();
         clear_br();
         check("vec_misalign", {31'd0, misalign}, {31'd0, vecs[v].exp_mis});
         if (vecs[v].exp_redir) begin
            check("vec_req", {31'd0, imem_req}, 32'd1);
            check("vec_target", imem_addr, vecs[v].exp_tgt);
            check("vec_valid", {31'd0, instr_valid}, 32'd0);
         end else begin
            check("vec_nochg_req", {31'd0, imem_req}, 32'd0);
            check("vec_nochg_valid", {31'd0, instr_valid}, 32'd1);
            check("vec_nochg_pc", pc, 32'h0040_0004);
         end
         tick();
         check("vec_misalign_pulse", {31'd0, misalign}, 32'd0);
      end

      // Redirect in FETCH without ack: drain, discard stale data, refetch
      reset_dut();
      br_valid = 1'b1;
      br_type  = 2'b01;
      br_imm   = 26'h0100040;
      br_pc    = 32'h0040_0000;
      tick();
      clear_br();
      check("drain_req", {31'd0, imem_req}, 32'd0);
      check("drain_pc", pc, 32'h0040_0100);
      for (int k = 0; k < 2; k++) begin
         tick();
         check("drain_wait_req", {31'd0, imem_req}, 32'd0);
         check("drain_wait_valid", {31'd0, instr_valid}, 32'd0);
      end
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack = 1'b0;
      check("drain_stale_valid", {31'd0, instr_valid}, 32'd0);
      check("drain_refetch_req", {31'd0, imem_req}, 32'd1);
      check("drain_refetch_addr", imem_addr, 32'h0040_0100);
      imem_ack = 1'b1;
      imem_rdata = 32'h1111_1111;
      tick();
      imem_ack = 1'b0;
      check("drain_new_valid", {31'd0, instr_valid}, 32'd1);
      check("drain_new_instr", instr, 32'h1111_1111);
      check("drain_new_pc", instr_pc, 32'h0040_0100);

      // Redirect in FETCH with ack in the same cycle
      reset_dut();
      imem_ack = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      br_valid = 1'b1;
      br_type  = 2'b10;
      br_reg   = 32'h0040_0200;
      tick();
      imem_ack = 1'b0;
      clear_br();
      check("fack_req", {31'd0, imem_req}, 32'd1);
      check("fack_addr", imem_addr, 32'h0040_0200);
      check("fack_valid", {31'd0, instr_valid}, 32'd0);

      // Redirect in HOLD while decode is ready: squash
      reset_dut();
      imem_ack = 1'b1;
      imem_rdata = 32'h2222_2222;
      tick();
      imem_ack = 1'b0;
      check("squash_hold_valid", {31'd0, instr_valid}, 32'd1);
      instr_ready = 1'b1;
      br_valid = 1'b1;
      br_type  = 2'b00;
      br_taken = 1'b1;
      br_imm   = 26'h0000010;
      br_pc    = 32'h0040_0000;
      tick();
      clear_br();
      instr_ready = 1'b0;
      check("squash_valid", {31'd0, instr_valid}, 32'd0);
      check("squash_req", {31'd0, imem_req}, 32'd1);
      check("squash_addr", imem_addr, 32'h0040_0044);

      // Reset while a request is outstanding, with stray acks
      reset_dut();
      imem_ack = 1'b1;
      imem_rdata = 32'h3333_3333;
      instr_ready = 1'b1;
      tick();
      imem_ack = 1'b0;
      tick();
      check("mid_pre_req", {31'd0, imem_req}, 32'd1);
      check("mid_pre_addr", imem_addr, 32'h0040_0004);
      rst = 1'b1;
      #1;
      check("mid_rst_req", {31'd0, imem_req}, 32'd0);
      check("mid_rst_pc", pc, 32'h0040_0000);
      check("mid_rst_instr", instr, 32'd0);
      check("mid_rst_instr_pc", instr_pc, 32'd0);
      imem_ack = 1'b1;
      imem_rdata = 32'h4444_4444;
      tick();
      tick();
      rst = 1'b0;
      tick();
      imem_ack = 1'b0;
      check("stray_req", {31'd0, imem_req}, 32'd1);
      check("stray_addr", imem_addr, 32'h0040_0000);
      check("stray_valid", {31'd0, instr_valid}, 32'd0);
      check("stray_instr", instr, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
